// File: rtl/noc_pkg.sv
// Shared definitions for the B-tree NoC centre switch: port indices, drop-counter width
// and destination-address extraction from a flit.
package noc_pkg;
  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = 2;
  localparam int TL        = 0;
  localparam int BL        = 1;
  localparam int TR        = 2;
  localparam int BR        = 3;
  localparam int DROP_W    = 8;
  localparam int MAX_DW    = 256;
  localparam int MAX_AW    = 16;

  // Address sits in the top aw bits of a dw-bit flit; callers zero-extend the flit to MAX_DW.
  function automatic logic [MAX_AW-1:0] flit_addr(input logic [MAX_DW-1:0] flit,
                                                  input int dw, input int aw);
    return MAX_AW'(flit >> (dw - aw)) & ((MAX_AW'(1) << aw) - MAX_AW'(1));
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, FifoDepth entries; head is visible combinationally the cycle after a push.
// Push when full and pop when empty are ignored; full/empty come from the registered count.
module sync_fifo #(
  parameter int DataWidth = 36,
  parameter int FifoDepth = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_push,
  input  logic [DataWidth-1:0]         i_data,
  input  logic                         i_pop,
  output logic [DataWidth-1:0]         o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(FifoDepth):0]   o_count
);
  localparam int PtrW = $clog2(FifoDepth);

  logic [DataWidth-1:0] r_mem [FifoDepth];
  logic [PtrW-1:0]      r_wptr;
  logic [PtrW-1:0]      r_rptr;
  logic [PtrW:0]        r_count;
  logic                 w_push;
  logic                 w_pop;

  assign o_full  = (r_count == (PtrW+1)'(FifoDepth));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PtrW+1)'(1);
        2'b01:   r_count <= r_count - (PtrW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/centre_quad_switch.sv
// Four-port buffered crossbar: input FIFO, first-match address decode, round-robin per output,
// registered egress (2 edges ingress-to-egress); a stalled output holds its flit and grants nothing.
module centre_quad_switch
  import noc_pkg::*;
#(
  parameter int DataWidth = 36,
  parameter int AddrWidth = 4,
  parameter int FifoDepth = 4,
  parameter int P0Min = 0, parameter int P0Max = 0,
  parameter int P1Min = 1, parameter int P1Max = 1,
  parameter int P2Min = 2, parameter int P2Max = 2,
  parameter int P3Min = 3, parameter int P3Max = 3
) (
  input  logic                 i_sclk,
  input  logic                 i_reset,
  input  logic [DataWidth-1:0] i_topLeft_data,
  input  logic                 i_topLeft_data_valid,
  output logic                 o_topLeft_data_ready,
  output logic [DataWidth-1:0] o_topLeft_data,
  output logic                 o_topLeft_data_valid,
  input  logic                 i_topLeft_data_ready,
  input  logic [DataWidth-1:0] i_bottomLeft_data,
  input  logic                 i_bottomLeft_data_valid,
  output logic                 o_bottomLeft_data_ready,
  output logic [DataWidth-1:0] o_bottomLeft_data,
  output logic                 o_bottomLeft_data_valid,
  input  logic                 i_bottomLeft_data_ready,
  input  logic [DataWidth-1:0] i_topRight_data,
  input  logic                 i_topRight_data_valid,
  output logic                 o_topRight_data_ready,
  output logic [DataWidth-1:0] o_topRight_data,
  output logic                 o_topRight_data_valid,
  input  logic                 i_topRight_data_ready,
  input  logic [DataWidth-1:0] i_bottomRight_data,
  input  logic                 i_bottomRight_data_valid,
  output logic                 o_bottomRight_data_ready,
  output logic [DataWidth-1:0] o_bottomRight_data,
  output logic                 o_bottomRight_data_valid,
  input  logic                 i_bottomRight_data_ready,
  output logic [DROP_W-1:0]    o_drop_count
);
  localparam int CntW = $clog2(FifoDepth) + 1;
  localparam int PMIN [NUM_PORTS] = '{P0Min, P1Min, P2Min, P3Min};
  localparam int PMAX [NUM_PORTS] = '{P0Max, P1Max, P2Max, P3Max};

  logic [DataWidth-1:0] w_in_dat  [NUM_PORTS];
  logic [DataWidth-1:0] w_head    [NUM_PORTS];
  logic [AddrWidth-1:0] w_addr    [NUM_PORTS];
  logic [CntW-1:0]      w_count   [NUM_PORTS];
  logic [PORT_W-1:0]    w_dest    [NUM_PORTS];
  logic [PORT_W-1:0]    w_gnt_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_in_vld, w_in_rdy, w_out_rdy, w_push, w_pop;
  logic [NUM_PORTS-1:0] w_full, w_empty, w_route_ok, w_req, w_drop, w_load, w_gnt_vld;
  logic [DROP_W:0]      w_drop_sum;

  logic [DataWidth-1:0] r_out_dat [NUM_PORTS];
  logic [PORT_W-1:0]    r_ptr     [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_out_vld;
  logic [DROP_W-1:0]    r_drop_cnt;

  assign w_in_dat[TL] = i_topLeft_data;
  assign w_in_dat[BL] = i_bottomLeft_data;
  assign w_in_dat[TR] = i_topRight_data;
  assign w_in_dat[BR] = i_bottomRight_data;
  assign w_in_vld  = {i_bottomRight_data_valid, i_topRight_data_valid,
                      i_bottomLeft_data_valid, i_topLeft_data_valid};
  assign w_out_rdy = {i_bottomRight_data_ready, i_topRight_data_ready,
                      i_bottomLeft_data_ready, i_topLeft_data_ready};

  assign o_topLeft_data_ready     = w_in_rdy[TL];
  assign o_bottomLeft_data_ready  = w_in_rdy[BL];
  assign o_topRight_data_ready    = w_in_rdy[TR];
  assign o_bottomRight_data_ready = w_in_rdy[BR];
  assign o_topLeft_data           = r_out_dat[TL];
  assign o_bottomLeft_data        = r_out_dat[BL];
  assign o_topRight_data          = r_out_dat[TR];
  assign o_bottomRight_data       = r_out_dat[BR];
  assign o_topLeft_data_valid     = r_out_vld[TL];
  assign o_bottomLeft_data_valid  = r_out_vld[BL];
  assign o_topRight_data_valid    = r_out_vld[TR];
  assign o_bottomRight_data_valid = r_out_vld[BR];
  assign o_drop_count             = r_drop_cnt;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_in
    // Ready is gated by reset so nothing is accepted while the switch is being cleared.
    assign w_in_rdy[g] = !w_full[g] && !i_reset;
    assign w_push[g]   = w_in_vld[g] && w_in_rdy[g];
    assign w_addr[g]   = AddrWidth'(flit_addr(MAX_DW'(w_head[g]), DataWidth, AddrWidth));

    sync_fifo #(.DataWidth(DataWidth), .FifoDepth(FifoDepth)) u_fifo (
      .i_clk   (i_sclk),
      .i_reset (i_reset),
      .i_push  (w_push[g]),
      .i_data  (w_in_dat[g]),
      .i_pop   (w_pop[g]),
      .o_data  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_count (w_count[g])
    );

    a_count_bound: assert property (@(posedge i_sclk) disable iff (i_reset)
      w_full[g] == (w_count[g] == CntW'(FifoDepth)));
  end

  // Ranges are scanned high-to-low so the lowest matching port is the last writer and wins.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_route_ok[i] = 1'b0;
      w_dest[i]     = '0;
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (int'(w_addr[i]) >= PMIN[p] && int'(w_addr[i]) <= PMAX[p]) begin
          w_route_ok[i] = 1'b1;
          w_dest[i]     = PORT_W'(p);
        end
      end
      w_req[i]  = !w_empty[i] && w_route_ok[i];
      w_drop[i] = !w_empty[i] && !w_route_ok[i];
    end
  end

  always_comb begin
    logic [PORT_W-1:0] v_idx;
    v_idx = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_load[o]    = !r_out_vld[o] || w_out_rdy[o];
      w_gnt_vld[o] = 1'b0;
      w_gnt_idx[o] = '0;
      if (w_load[o]) begin
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
          v_idx = r_ptr[o] + PORT_W'(k);
          if (w_req[v_idx] && w_dest[v_idx] == PORT_W'(o)) begin
            w_gnt_vld[o] = 1'b1;
            w_gnt_idx[o] = v_idx;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_pop[i] = w_drop[i];
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_gnt_vld[o] && w_gnt_idx[o] == PORT_W'(i)) w_pop[i] = 1'b1;
      end
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + (DROP_W+1)'($countones(w_drop));

  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      r_out_vld  <= '0;
      r_drop_cnt <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_out_dat[o] <= '0;
        r_ptr[o]     <= '0;
      end
    end else begin
      r_drop_cnt <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_load[o]) begin
          r_out_vld[o] <= w_gnt_vld[o];
          if (w_gnt_vld[o]) begin
            r_out_dat[o] <= w_head[w_gnt_idx[o]];
            r_ptr[o]     <= w_gnt_idx[o] + PORT_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_centre_quad_switch.sv
// Bench for centre_quad_switch: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_centre_quad_switch;
  localparam int DW    = 36;
  localparam int DEPTH = 4;
  localparam int RMIN [4] = '{0, 1, 2, 3};
  localparam int RMAX [4] = '{0, 1, 2, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] in_dat [4];
  logic          in_vld [4];
  logic          out_rdy [4];
  logic [DW-1:0] o_dat [4];
  logic          o_vld [4];
  logic          o_rdy [4];
  logic [7:0]    drop;

  logic [DW-1:0] ov_dat;
  logic          ov_vld;
  logic [DW-1:0] ov_o_dat [4];
  logic          ov_o_vld [4];
  logic          ov_o_rdy [4];
  logic [7:0]    ov_drop;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  centre_quad_switch dut (
    .i_sclk(clk), .i_reset(rst),
    .i_topLeft_data(in_dat[0]), .i_topLeft_data_valid(in_vld[0]), .o_topLeft_data_ready(o_rdy[0]),
    .o_topLeft_data(o_dat[0]), .o_topLeft_data_valid(o_vld[0]), .i_topLeft_data_ready(out_rdy[0]),
    .i_bottomLeft_data(in_dat[1]), .i_bottomLeft_data_valid(in_vld[1]), .o_bottomLeft_data_ready(o_rdy[1]),
    .o_bottomLeft_data(o_dat[1]), .o_bottomLeft_data_valid(o_vld[1]), .i_bottomLeft_data_ready(out_rdy[1]),
    .i_topRight_data(in_dat[2]), .i_topRight_data_valid(in_vld[2]), .o_topRight_data_ready(o_rdy[2]),
    .o_topRight_data(o_dat[2]), .o_topRight_data_valid(o_vld[2]), .i_topRight_data_ready(out_rdy[2]),
    .i_bottomRight_data(in_dat[3]), .i_bottomRight_data_valid(in_vld[3]), .o_bottomRight_data_ready(o_rdy[3]),
    .o_bottomRight_data(o_dat[3]), .o_bottomRight_data_valid(o_vld[3]), .i_bottomRight_data_ready(out_rdy[3]),
    .o_drop_count(drop)
  );

  centre_quad_switch #(.P0Max(1), .P1Max(1)) dut_ov (
    .i_sclk(clk), .i_reset(rst),
    .i_topLeft_data(ov_dat), .i_topLeft_data_valid(ov_vld), .o_topLeft_data_ready(ov_o_rdy[0]),
    .o_topLeft_data(ov_o_dat[0]), .o_topLeft_data_valid(ov_o_vld[0]), .i_topLeft_data_ready(1'b1),
    .i_bottomLeft_data('0), .i_bottomLeft_data_valid(1'b0), .o_bottomLeft_data_ready(ov_o_rdy[1]),
    .o_bottomLeft_data(ov_o_dat[1]), .o_bottomLeft_data_valid(ov_o_vld[1]), .i_bottomLeft_data_ready(1'b1),
    .i_topRight_data('0), .i_topRight_data_valid(1'b0), .o_topRight_data_ready(ov_o_rdy[2]),
    .o_topRight_data(ov_o_dat[2]), .o_topRight_data_valid(ov_o_vld[2]), .i_topRight_data_ready(1'b1),
    .i_bottomRight_data('0), .i_bottomRight_data_valid(1'b0), .o_bottomRight_data_ready(ov_o_rdy[3]),
    .o_bottomRight_data(ov_o_dat[3]), .o_bottomRight_data_valid(ov_o_vld[3]), .i_bottomRight_data_ready(1'b1),
    .o_drop_count(ov_drop)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int route(input logic [DW-1:0] f);
    int a;
    a = int'(f[DW-1 -: 4]);
    for (int p = 0; p < 4; p++) if (a >= RMIN[p] && a <= RMAX[p]) return p;
    return -1;
  endfunction

  // Reference model: per-input queues, per-output holding slot and round-robin pointer.
  logic [DW-1:0] mq [4][$];
  logic          m_vld [4];
  logic [DW-1:0] m_dat [4];
  int            m_ptr [4];
  int            m_drop;

  always @(posedge clk) begin
    bit acc [4];
    int hr [4];
    int g;
    if (rst) begin
      for (int p = 0; p < 4; p++) begin
        mq[p].delete(); m_vld[p] = 1'b0; m_dat[p] = '0; m_ptr[p] = 0;
      end
      m_drop = 0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        acc[p] = in_vld[p] && (mq[p].size() < DEPTH);
        hr[p]  = (mq[p].size() > 0) ? route(mq[p][0]) : -2;
      end
      for (int o = 0; o < 4; o++) begin
        if (!m_vld[o] || out_rdy[o]) begin
          g = -1;
          for (int k = 0; k < 4; k++) if (g < 0 && hr[(m_ptr[o] + k) % 4] == o) g = (m_ptr[o] + k) % 4;
          if (g >= 0) begin
            m_dat[o] = mq[g].pop_front(); m_vld[o] = 1'b1; m_ptr[o] = (g + 1) % 4;
          end else m_vld[o] = 1'b0;
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (hr[p] == -1) begin
          void'(mq[p].pop_front());
          if (m_drop < 255) m_drop++;
        end
        if (acc[p]) mq[p].push_back(in_dat[p]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < 4; p++) begin
        check($sformatf("model_vld_p%0d", p), 64'(o_vld[p]), 64'(m_vld[p]));
        if (m_vld[p]) check($sformatf("model_dat_p%0d", p), 64'(o_dat[p]), 64'(m_dat[p]));
        check($sformatf("model_rdy_p%0d", p), 64'(o_rdy[p]), 64'(!rst && mq[p].size() < DEPTH));
      end
      check("model_drop", 64'(drop), 64'(m_drop));
    end
  end

  logic [DW-1:0] rec [4][$];
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) if (o_vld[p] && out_rdy[p]) rec[p].push_back(o_dat[p]);
  end

  task automatic clear_rec();
    for (int p = 0; p < 4; p++) rec[p].delete();
  endtask

  task automatic push_flit(input int p, input logic [DW-1:0] f);
    bit acc;
    int t;
    in_dat[p] = f; in_vld[p] = 1'b1; acc = 1'b0; t = 0;
    while (!acc && t < 200) begin
      @(negedge clk); acc = o_rdy[p];
      @(posedge clk); #1; t++;
    end
    if (!acc) check($sformatf("push_timeout_p%0d", p), 64'(acc), 64'(1));
  endtask

  task automatic stream(input int p, input int n);
    for (int k = 0; k < n; k++) push_flit(p, {4'd3, 24'h0, 4'(p), 4'(k)});
    in_vld[p] = 1'b0;
  endtask

  task automatic wait_rec(input int p, input int n);
    int t;
    t = 0;
    while (rec[p].size() < n && t < 300) begin @(negedge clk); t++; end
    if (rec[p].size() < n) check($sformatf("rec_timeout_p%0d", p), 64'(rec[p].size()), 64'(n));
  endtask

  initial begin
    int found, t;
    for (int p = 0; p < 4; p++) begin in_dat[p] = '0; in_vld[p] = 1'b0; out_rdy[p] = 1'b1; end
    ov_dat = '0; ov_vld = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    for (int p = 0; p < 4; p++) check($sformatf("rst_rdy_low_p%0d", p), 64'(o_rdy[p]), 64'(0));
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      check($sformatf("rst_rdy_p%0d", p), 64'(o_rdy[p]), 64'(1));
      check($sformatf("rst_vld_p%0d", p), 64'(o_vld[p]), 64'(0));
      check($sformatf("rst_dat_p%0d", p), 64'(o_dat[p]), 64'(0));
    end
    check("rst_drop", 64'(drop), 64'(0));

    // Single flit topLeft -> addr 2: egress register loads one edge after the FIFO write.
    clear_rec();
    @(posedge clk); #1; in_dat[0] = 36'h2_0000_00AB; in_vld[0] = 1'b1;
    @(posedge clk); #1; in_vld[0] = 1'b0;
    @(negedge clk); check("single_not_early", 64'(o_vld[2]), 64'(0));
    @(negedge clk); check("single_vld", 64'(o_vld[2]), 64'(1));
    check("single_dat", 64'(o_dat[2]), 64'h2_0000_00AB);
    @(negedge clk); check("single_one_cycle", 64'(o_vld[2]), 64'(0));

    // Round robin: four sources to addr 3, sink always ready.
    clear_rec();
    @(posedge clk); #1;
    fork
      stream(0, 10); stream(1, 10); stream(2, 10); stream(3, 10);
    join
    wait_rec(3, 40);
    for (int k = 0; k < 40 && k < rec[3].size(); k++)
      check($sformatf("rr_src_%0d", k), 64'(rec[3][k][7:4]), 64'(k % 4));

    // Backpressure on topLeft egress while topRight sends six flits to addr 0.
    clear_rec();
    @(posedge clk); #1; out_rdy[0] = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) push_flit(2, {4'd0, 24'h0, 4'h2, 4'(k)});
        in_vld[2] = 1'b0;
      end
      begin
        repeat (12) @(negedge clk);
        check("bp_rdy_low", 64'(o_rdy[2]), 64'(0));
        check("bp_hold_vld", 64'(o_vld[0]), 64'(1));
        check("bp_hold_dat", 64'(o_dat[0]), 64'({4'd0, 24'h0, 4'h2, 4'h0}));
        @(posedge clk); #1; out_rdy[0] = 1'b1;
      end
    join
    wait_rec(0, 6);
    check("bp_count", 64'(rec[0].size()), 64'(6));
    for (int k = 0; k < 6 && k < rec[0].size(); k++)
      check($sformatf("bp_order_%0d", k), 64'(rec[0][k]), 64'({4'd0, 24'h0, 4'h2, 4'(k)}));

    // Unroutable address 9 from bottomLeft.
    clear_rec();
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) push_flit(1, {4'd9, 32'(k)});
    in_vld[1] = 1'b0;
    repeat (5) @(negedge clk);
    check("drop_3", 64'(drop), 64'(3));
    check("drop_no_egress", 64'(rec[0].size() + rec[1].size() + rec[2].size() + rec[3].size()), 64'(0));
    @(posedge clk); #1;
    for (int k = 0; k < 300; k++) push_flit(1, {4'd9, 32'(k)});
    in_vld[1] = 1'b0;
    repeat (5) @(negedge clk);
    check("drop_sat", 64'(drop), 64'(255));

    // Reset while flits are buffered behind a stalled output.
    @(posedge clk); #1; out_rdy[1] = 1'b0;
    for (int k = 0; k < 3; k++) push_flit(0, {4'd1, 32'(k)});
    in_vld[0] = 1'b0;
    rst = 1'b1; clear_rec();
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 4; p++) check($sformatf("mid_rst_vld_p%0d", p), 64'(o_vld[p]), 64'(0));
    check("mid_rst_drop", 64'(drop), 64'(0));
    @(posedge clk); #1; out_rdy[1] = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_rst_no_stale", 64'(rec[0].size() + rec[1].size() + rec[2].size() + rec[3].size()), 64'(0));

    // Overlapping ranges: addr 1 from topLeft exits topLeft on the second instance.
    @(posedge clk); #1; ov_dat = {4'd1, 32'hCAFE}; ov_vld = 1'b1;
    @(posedge clk); #1; ov_vld = 1'b0;
    found = -1; t = 0;
    while (found < 0 && t < 10) begin
      @(negedge clk);
      for (int p = 3; p >= 0; p--) if (ov_o_vld[p]) found = p;
      t++;
    end
    check("ov_port", 64'(found), 64'(0));
    check("ov_dat", 64'(ov_o_dat[0]), 64'({4'd1, 32'hCAFE}));

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
